// File: rtl/prbs_rand_gen_if.sv
// Bundle of the LFSR control, state and bounded-draw handshake signals.
interface prbs_rand_gen_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OUTW  = 8
) ();

  logic             shiftEn;
  logic             seedLoad;
  logic [WIDTH-1:0] seedIn;
  logic [WIDTH-1:0] outSeq;
  logic             req;
  logic [OUTW-1:0]  limit;
  logic             busy;
  logic             randValid;
  logic [OUTW-1:0]  randOut;
  logic             randErr;

  // Requester side: drives control and draw requests.
  modport master (
    output shiftEn, seedLoad, seedIn, req, limit,
    input  outSeq, busy, randValid, randOut, randErr
  );

  // Generator side.
  modport slave (
    input  shiftEn, seedLoad, seedIn, req, limit,
    output outSeq, busy, randValid, randOut, randErr
  );

endinterface

// File: rtl/prbs_rand_gen.sv
// Fibonacci LFSR pseudo-random generator with seed load, lock-up guard and a
// rejection-sampling bounded draw returning a value in [0, limit-1].
module prbs_rand_gen #(
  parameter int unsigned      WIDTH  = 16,
  parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
  parameter logic [WIDTH-1:0] SEED   = 16'hACE1,
  parameter int unsigned      OUTW   = 8,
  parameter int unsigned      MAXTRY = 15
) (
  input logic            clk,
  input logic            rst,
  prbs_rand_gen_if.slave bus
);

  localparam int unsigned     TryW   = (MAXTRY > 0) ? $clog2(MAXTRY + 1) : 1;
  localparam logic [TryW-1:0] MaxTry = TryW'(MAXTRY);

  typedef enum logic [0:0] {StIdle, StDraw} st_e;

  st_e              fsm_q;
  logic [WIDTH-1:0] state_q, state_d, state_step;
  logic [TryW-1:0]  tries_q;
  logic [OUTW-1:0]  lim_q;
  logic [OUTW-1:0]  out_q;
  logic             busy_q, valid_q, err_q;
  logic [OUTW-1:0]  cand;
  logic             accept, retry;

  // Candidate evaluation and next LFSR state (seed load beats stepping).
  always_comb begin
    cand       = state_q[OUTW-1:0];
    accept     = (cand < lim_q);
    // Only a retry advances the LFSR; the fallback cycle leaves it in place.
    retry      = (fsm_q == StDraw) && !accept && (tries_q != MaxTry);
    state_step = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    state_d    = state_q;
    if (bus.seedLoad) begin
      // An all-zero seed would lock the LFSR, so substitute the default seed.
      state_d = (bus.seedIn == '0) ? SEED : bus.seedIn;
    end else if (bus.shiftEn || retry) begin
      state_d = state_step;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  // Draw FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q   <= StIdle;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
      err_q   <= 1'b0;
      tries_q <= '0;
      lim_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (fsm_q)
        StIdle: begin
          if (bus.req) begin
            if (bus.limit == '0) begin
              // Empty range: report an error immediately without drawing.
              valid_q <= 1'b1;
              out_q   <= '0;
              err_q   <= 1'b1;
            end else begin
              lim_q   <= bus.limit;
              tries_q <= '0;
              busy_q  <= 1'b1;
              fsm_q   <= StDraw;
            end
          end
        end
        StDraw: begin
          if (accept) begin
            out_q   <= cand;
            valid_q <= 1'b1;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            fsm_q   <= StIdle;
          end else if (tries_q == MaxTry) begin
            out_q   <= '0;
            valid_q <= 1'b1;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            fsm_q   <= StIdle;
          end else begin
            tries_q <= tries_q + 1'b1;
          end
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end

  assign bus.outSeq    = state_q;
  assign bus.busy      = busy_q;
  assign bus.randValid = valid_q;
  assign bus.randOut   = out_q;
  assign bus.randErr   = err_q;

endmodule

// File: tb/tb_prbs_rand_gen.sv
// Directed and randomised checks of prbs_rand_gen against a polynomial-level
// LFSR model and a draw-outcome scoreboard.
module tb_prbs_rand_gen;

  localparam int unsigned MaxTry = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  prbs_rand_gen_if #(.WIDTH(16), .OUTW(8)) bus ();

  prbs_rand_gen #(
    .WIDTH (16),
    .TAPS  (16'hB400),
    .SEED  (16'hACE1),
    .OUTW  (8),
    .MAXTRY(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [7:0]  val;
    logic        err;
    logic [4:0]  lat;
    logic [15:0] fin;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] ref_q;
  exp_t        sb[$];

  // x16+x14+x13+x11 written out as explicit bit positions.
  function automatic logic [15:0] nxt(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Outcome of a draw starting from state s0 with no external stepping.
  function automatic exp_t predict(input logic [15:0] s0, input logic [7:0] lim);
    exp_t        e;
    logic [15:0] s;
    bit          done;
    s     = s0;
    done  = 1'b0;
    e.val = 8'h00;
    e.err = 1'b1;
    e.lat = 5'd0;
    e.fin = s0;
    if (lim != 8'd0) begin
      for (int k = 0; k <= int'(MaxTry); k++) begin
        if (!done) begin
          if (s[7:0] < lim) begin
            e.val = s[7:0];
            e.err = 1'b0;
            e.lat = 5'(k + 1);
            e.fin = s;
            done  = 1'b1;
          end else if (k == int'(MaxTry)) begin
            e.val = 8'h00;
            e.err = 1'b1;
            e.lat = 5'(k + 1);
            e.fin = s;
            done  = 1'b1;
          end else begin
            s = nxt(s);
          end
        end
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst   = 1'b1;
    ref_q = 16'hACE1;
  endtask

  // Issue one draw; with noisy set, hammer req/limit while busy.
  task automatic draw(input logic [7:0] lim, input bit noisy);
    exp_t e;
    int   n;
    bit   got;
    sb.push_back(predict(ref_q, lim));
    bus.req   = 1'b1;
    bus.limit = lim;
    tick();
    bus.req = 1'b0;
    n       = 0;
    got     = bus.randValid;
    if (lim != 8'd0) chk("busy_after_req", {31'd0, bus.busy}, 32'd1);
    while (!got && n < 20) begin
      if (noisy) begin
        bus.req   = 1'($urandom_range(0, 1));
        bus.limit = 8'($urandom);
      end
      tick();
      bus.req = 1'b0;
      n++;
      got = bus.randValid;
    end
    e = sb.pop_front();
    chk("draw_valid", {31'd0, got}, 32'd1);
    chk("rand_out", {24'd0, bus.randOut}, {24'd0, e.val});
    chk("rand_err", {31'd0, bus.randErr}, {31'd0, e.err});
    chk("latency", n, {27'd0, e.lat});
    chk("state_after_draw", {16'd0, bus.outSeq}, {16'd0, e.fin});
    chk("busy_done", {31'd0, bus.busy}, 32'd0);
    chk("in_range", {31'd0, (bus.randOut < lim) | bus.randErr}, 32'd1);
    ref_q = e.fin;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          mism;
    bit          zero_seen;
    bit          seen;

    bus.shiftEn  = 1'b0;
    bus.seedLoad = 1'b0;
    bus.seedIn   = 16'h0000;
    bus.req      = 1'b0;
    bus.limit    = 8'h00;
    rst          = 1'b0;
    tick();
    tick();
    chk("rst_outseq", {16'd0, bus.outSeq}, 32'h0000ACE1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_valid", {31'd0, bus.randValid}, 32'd0);
    chk("rst_out", {24'd0, bus.randOut}, 32'd0);
    chk("rst_err", {31'd0, bus.randErr}, 32'd0);
    rst   = 1'b1;
    ref_q = 16'hACE1;
    tick();
    chk("hold", {16'd0, bus.outSeq}, 32'h0000ACE1);

    bus.shiftEn = 1'b1;
    tick();
    bus.shiftEn = 1'b0;
    ref_q       = nxt(ref_q);
    chk("step1", {16'd0, bus.outSeq}, 32'h000059C3);
    chk("step1_model", {16'd0, bus.outSeq}, {16'd0, ref_q});

    // Full period from the seed.
    bus.seedLoad = 1'b1;
    bus.seedIn   = 16'hACE1;
    tick();
    bus.seedLoad = 1'b0;
    ref_q        = 16'hACE1;
    bus.shiftEn  = 1'b1;
    n            = 0;
    mism         = 0;
    zero_seen    = 1'b0;
    while (n < 70000) begin
      tick();
      n++;
      ref_q = nxt(ref_q);
      if (bus.outSeq === 16'h0000) zero_seen = 1'b1;
      if (bus.outSeq !== ref_q) mism++;
      if (bus.outSeq === 16'hACE1) break;
    end
    bus.shiftEn = 1'b0;
    chk("period", n, 32'd65535);
    chk("never_zero", {31'd0, zero_seen}, 32'd0);
    chk("period_seq", mism, 32'd0);
    ref_q = bus.outSeq;

    // Seed load, lock-up guard, load over step.
    bus.seedLoad = 1'b1;
    bus.seedIn   = 16'h0000;
    tick();
    chk("seed_zero_guard", {16'd0, bus.outSeq}, 32'h0000ACE1);
    bus.seedIn = 16'h1234;
    tick();
    chk("seed_1234", {16'd0, bus.outSeq}, 32'h00001234);
    bus.seedIn  = 16'h5678;
    bus.shiftEn = 1'b1;
    tick();
    bus.seedLoad = 1'b0;
    bus.shiftEn  = 1'b0;
    chk("load_beats_step", {16'd0, bus.outSeq}, 32'h00005678);

    // First draw from reset with full range.
    do_reset();
    draw(8'hFF, 1'b0);
    chk("first_draw_const", {24'd0, bus.randOut}, 32'h000000E1);
    tick();
    chk("valid_pulse", {31'd0, bus.randValid}, 32'd0);
    chk("out_held", {24'd0, bus.randOut}, 32'h000000E1);

    // Empty range and narrow range with fallback.
    draw(8'd0, 1'b0);
    do_reset();
    draw(8'd1, 1'b0);

    // Seed load mid-draw overrides the retry step.
    do_reset();
    bus.req   = 1'b1;
    bus.limit = 8'd1;
    tick();
    bus.req      = 1'b0;
    bus.seedLoad = 1'b1;
    bus.seedIn   = 16'h1200;
    tick();
    bus.seedLoad = 1'b0;
    chk("seed_mid_draw_state", {16'd0, bus.outSeq}, 32'h00001200);
    tick();
    chk("seed_mid_draw_valid", {31'd0, bus.randValid}, 32'd1);
    chk("seed_mid_draw_out", {24'd0, bus.randOut}, 32'd0);
    chk("seed_mid_draw_err", {31'd0, bus.randErr}, 32'd0);
    ref_q = 16'h1200;

    // Random limits with busy-time noise and occasional free-running steps.
    for (int i = 0; i < 1000; i++) begin
      draw(8'($urandom_range(1, 255)), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        bus.shiftEn = 1'b1;
        tick();
        bus.shiftEn = 1'b0;
        ref_q       = nxt(ref_q);
      end
    end

    // Reset while a draw is in progress.
    do_reset();
    bus.req   = 1'b1;
    bus.limit = 8'd1;
    tick();
    bus.req = 1'b0;
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_valid", {31'd0, bus.randValid}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_state", {16'd0, bus.outSeq}, 32'h0000ACE1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.randValid === 1'b1) seen = 1'b1;
    end
    chk("no_valid_after_rst", {31'd0, seen}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
